// File: rtl/apb_gpio_slave.sv
// APB GPIO slave: OUT register drives gpio_out, IN register returns two-flop synchronized gpio_in.
// Latency: PREADY rises in access cycle WAIT_CYCLES+1; IN register lags the pins by 2 PCLK cycles.
// Backpressure: PREADY is held low for WAIT_CYCLES access cycles; dropping PSEL aborts without side effects.
// Optional feature macro: GPIO_PSLVERR_EN adds the PSLVERR error-response port.
module apb_gpio_slave #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] OUT_RESET   = 32'h0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
`ifdef GPIO_PSLVERR_EN
    ,
    output logic        PSLVERR
`endif
);

    localparam logic [31:0] ADDR_OUT  = 32'h0000_1000;
    localparam logic [31:0] ADDR_IN   = 32'h0000_1004;
    localparam logic [3:0]  WAIT_N    = 4'(WAIT_CYCLES);
    localparam logic        ZERO_WAIT = (WAIT_N == 4'd0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_write;
    logic [31:0] sync_q1;
    logic [31:0] sync_q2;

    logic        sel;
    logic        setup;
    logic [3:0]  cnt_inc;
    logic        wait_done;
    logic        commit_wr;
    logic        enter_ready;
    logic [31:0] out_next;
    logic [31:0] tgt_addr;
    logic        tgt_write;
    logic [31:0] tgt_rdata;

    // Only the GPIO select code addresses this block; any other code is "not us".
    assign sel     = (PSEL == 2'b10);
    assign setup   = sel && !PENABLE;
    assign cnt_inc = wait_cnt + 4'd1;
    assign wait_done = (cnt_inc == WAIT_N);

    // A write lands only at the end of a READY cycle whose select is still held.
    assign commit_wr = (state == READY) && sel && cap_write && (cap_addr == ADDR_OUT);
    assign out_next  = commit_wr ? cap_wdata : gpio_out;

    // READY is entered either from WAIT (captured request) or straight from a
    // setup edge when no wait states are configured (live request).
    assign enter_ready = ((state == WAIT) && sel && wait_done) ||
                         ((state != WAIT) && setup && ZERO_WAIT);
    assign tgt_addr  = (state == WAIT) ? cap_addr  : PADDR;
    assign tgt_write = (state == WAIT) ? cap_write : PWRITE;

    // Read data for the transfer entering READY; OUT is forwarded so a read
    // chained directly behind a write sees the new value.
    always_comb begin
        tgt_rdata = 32'h0;
        if (!tgt_write) begin
            if (tgt_addr == ADDR_OUT) begin
                tgt_rdata = out_next;
            end else if (tgt_addr == ADDR_IN) begin
                tgt_rdata = sync_q2;
            end
        end
    end

`ifdef GPIO_PSLVERR_EN
    logic tgt_err;
    // Anything other than OUT access or IN read is an errored access.
    assign tgt_err = !((tgt_addr == ADDR_OUT) || ((tgt_addr == ADDR_IN) && !tgt_write));
`endif

    // Transfer FSM with registered PREADY/PRDATA/PSLVERR.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
            cap_write <= 1'b0;
            PREADY    <= 1'b0;
            PRDATA    <= 32'h0;
`ifdef GPIO_PSLVERR_EN
            PSLVERR   <= 1'b0;
`endif
        end else begin
            PREADY <= 1'b0;
            PRDATA <= 32'h0;
`ifdef GPIO_PSLVERR_EN
            PSLVERR <= 1'b0;
`endif
            case (state)
                IDLE, READY: begin
                    if (setup) begin
                        cap_addr  <= PADDR;
                        cap_wdata <= PWDATA;
                        cap_write <= PWRITE;
                        wait_cnt  <= 4'd0;
                        state     <= ZERO_WAIT ? READY : WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (!sel) begin
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                    end else if (wait_done) begin
                        state    <= READY;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
            if (enter_ready) begin
                PREADY <= 1'b1;
                PRDATA <= tgt_rdata;
`ifdef GPIO_PSLVERR_EN
                PSLVERR <= tgt_err;
`endif
            end
        end
    end

    // OUT register: changes only when a completed write to OUT commits.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            gpio_out <= OUT_RESET;
        end else begin
            gpio_out <= out_next;
        end
    end

    // Two-flop synchronizer for the asynchronous input pins.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_q1 <= 32'h0;
            sync_q2 <= 32'h0;
        end else begin
            sync_q1 <= gpio_in;
            sync_q2 <= sync_q1;
        end
    end

endmodule

// File: doc/apb_gpio_slave.md
APB_GPIO_SLAVE -- requirements
Module: apb_gpio_slave

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of wait states inserted in each access phase (legal range 0..15).
REQ-002 Parameter OUT_RESET, default 32'h0, reset value of the output data register.
REQ-003 PCLK  input  1  single clock; all state updates on its rising edge.
REQ-004 PRESET  input  1  reset, asynchronous, active-high.
REQ-005 PSEL  input  2  bus select; this block is selected only when PSEL==2'b10 (GPIO code).
REQ-006 PENABLE  input  1  access-phase indicator from the master.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  32  byte address.
REQ-009 PWDATA  input  32  write data.
REQ-010 PRDATA  output  32  read data.
REQ-011 PREADY  output  1  transfer completion from this block.
REQ-012 gpio_in  input  32  asynchronous external pins.
REQ-013 gpio_out  output  32  driven pin values.
REQ-014 PSLVERR  output  1  error response (present only with GPIO_PSLVERR_EN).

Function
REQ-015 Register map: 32'h1000 = OUT (read/write, drives gpio_out); 32'h1004 = IN (read-only, synchronized gpio_in); all other addresses are unmapped.
REQ-016 gpio_in is synchronized through a two-flop chain; IN reads return the second flop, giving a 2-cycle pin-to-register latency.
REQ-017 FSM states: IDLE, WAIT, READY.
REQ-018 IDLE -> WAIT on a setup cycle (PSEL==2'b10, PENABLE==0); address, direction and write data are captured at this edge.
REQ-019 In WAIT, a counter increments each access cycle; when the count equals WAIT_CYCLES, the state moves to READY. With WAIT_CYCLES==0, the setup edge goes directly to READY.
REQ-020 PREADY is registered and equals 1 only in READY; the access phase therefore lasts exactly WAIT_CYCLES+1 cycles.
REQ-021 A write to OUT updates gpio_out at the edge that ends the READY cycle; gpio_out changes at no other time.
REQ-022 A write to IN or to an unmapped address has no effect.
REQ-023 PRDATA carries the selected register while READY and PWRITE==0. It is 32'h0 at all other times, including unmapped reads.
REQ-024 READY -> WAIT (or READY when WAIT_CYCLES==0) if the same cycle is a new setup cycle; otherwise READY -> IDLE.
REQ-025 Abort: if PSEL!=2'b10 in WAIT or READY, go to IDLE; no register update and PREADY=0 next cycle.
REQ-026 PADDR/PWDATA changes during WAIT are ignored; the captured values are used.
REQ-027 PSEL values 2'b00, 2'b01 and 2'b11 never start a transfer.

Reset
REQ-028 While PRESET=1: state=IDLE, counter=0, PREADY=0, PRDATA=0, PSLVERR=0, gpio_out=OUT_RESET, synchronizer flops=0.
REQ-029 Reset asserted mid-transfer discards the transfer; no partial write occurs.

Configuration
REQ-030 Macro GPIO_PSLVERR_EN: when defined, PSLVERR exists and equals 1 in READY for an unmapped address or a write to IN, else 0.
REQ-031 When GPIO_PSLVERR_EN is undefined, the PSLVERR port is absent and errored accesses complete silently per REQ-022/REQ-023.

Verification
REQ-032 Write: WAIT_CYCLES=1, setup PADDR=32'h1000, PWRITE=1, PWDATA=32'hF0FF00F0 -> PREADY=1 in the 2nd access cycle; gpio_out=32'hF0FF00F0 after that edge.
REQ-033 Read: gpio_in=32'h0EC25F01 held 3 cycles, read 32'h1004 -> PRDATA=32'h0EC25F01 with PREADY=1; PRDATA=0 in the following cycle.
REQ-034 Zero-wait back-to-back: WAIT_CYCLES=0, write 32'h1000 then read 32'h1000 -> each access is 1 cycle; the read returns the written value.
REQ-035 Abort: drop PSEL to 2'b00 during WAIT of a write to 32'h1000 -> gpio_out unchanged; FSM IDLE; PREADY=0.
REQ-036 Unmapped/error: write 32'h2000 -> gpio_out unchanged; PSLVERR=1 with PREADY only when GPIO_PSLVERR_EN is defined.
REQ-037 Reset mid-write: assert PRESET in WAIT -> gpio_out=OUT_RESET, PREADY=0 immediately, no write.
